// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register: valid/ready handshake with a 2-entry skid
// buffer, synchronous flush that inserts a bubble, and a saturating bubble counter.
module pipe_stage_reg #(
    parameter int CTRL_W              = 36,
    parameter int DATA_W              = 192,
    parameter int CAPTURE_NEGEDGE     = 1,
    parameter int CTRL_ZERO_ON_BUBBLE = 1,
    parameter int BUB_CNT_W           = 16
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CTRL_W-1:0]    in_ctrl,
    input  logic [DATA_W-1:0]    in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CTRL_W-1:0]    out_ctrl,
    output logic [DATA_W-1:0]    out_data,
    output logic [BUB_CNT_W-1:0] bubble_cnt,
    input  logic                 clr_cnt
);

    typedef struct packed {
        logic                 main_v;
        logic [CTRL_W-1:0]    main_ctrl;
        logic [DATA_W-1:0]    main_data;
        logic                 skid_v;
        logic [CTRL_W-1:0]    skid_ctrl;
        logic [DATA_W-1:0]    skid_data;
        logic [BUB_CNT_W-1:0] bub_cnt;
    } stage_state_t;

    localparam logic [BUB_CNT_W-1:0] BUB_ONE = BUB_CNT_W'(1);
    localparam logic [BUB_CNT_W-1:0] BUB_MAX = '1;

    stage_state_t st_q;
    stage_state_t st_d;

    logic accept;
    logic pop;

    // Upstream readiness depends only on the skid flag, so out_ready never
    // reaches in_ready combinationally.
    assign in_ready   = !st_q.skid_v;
    assign accept     = in_valid && in_ready;
    assign pop        = st_q.main_v && out_ready;

    assign out_valid  = st_q.main_v;
    assign out_data   = st_q.main_data;
    assign out_ctrl   = ((CTRL_ZERO_ON_BUBBLE != 0) && !st_q.main_v) ? '0 : st_q.main_ctrl;
    assign bubble_cnt = st_q.bub_cnt;

    always_comb begin
        st_d = st_q;

        if (flush) begin
            // Data payload is left in place; only the valid flags and control
            // words are squashed so the slot reads as a NOP.
            st_d.main_v    = 1'b0;
            st_d.skid_v    = 1'b0;
            st_d.main_ctrl = '0;
            st_d.skid_ctrl = '0;
        end else if (!st_q.main_v || pop) begin
            if (st_q.skid_v) begin
                st_d.main_v    = 1'b1;
                st_d.main_ctrl = st_q.skid_ctrl;
                st_d.main_data = st_q.skid_data;
                st_d.skid_v    = 1'b0;
            end else if (accept) begin
                st_d.main_v    = 1'b1;
                st_d.main_ctrl = in_ctrl;
                st_d.main_data = in_data;
            end else begin
                st_d.main_v    = 1'b0;
            end
        end else if (accept) begin
            st_d.skid_v    = 1'b1;
            st_d.skid_ctrl = in_ctrl;
            st_d.skid_data = in_data;
        end

        if (clr_cnt) begin
            st_d.bub_cnt = '0;
        end else if (!st_q.main_v && (st_q.bub_cnt != BUB_MAX)) begin
            st_d.bub_cnt = st_q.bub_cnt + BUB_ONE;
        end
    end

    generate
        if (CAPTURE_NEGEDGE != 0) begin : g_cap_neg
            always_ff @(negedge Clk) begin
                if (Reset) begin
                    st_q <= '0;
                end else begin
                    st_q <= st_d;
                end
            end
        end else begin : g_cap_pos
            always_ff @(posedge Clk) begin
                if (Reset) begin
                    st_q <= '0;
                end else begin
                    st_q <= st_d;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed scenarios plus a random scoreboard run on a
// falling-edge instance, with a rising-edge twin checked for edge discipline and equivalence.
module tb_pipe_stage_reg;

    localparam int CW = 36;
    localparam int DW = 192;
    localparam int BW = 4;
    localparam int SW = 1 + 1 + CW + DW + BW;

    logic          Clk;
    logic          Reset;
    logic          flush;
    logic          in_valid;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;
    logic          out_ready;
    logic          clr_cnt;

    logic          in_ready,  in_ready_p;
    logic          out_valid, out_valid_p;
    logic [CW-1:0] out_ctrl,  out_ctrl_p;
    logic [DW-1:0] out_data,  out_data_p;
    logic [BW-1:0] bubble_cnt, bubble_cnt_p;

    int n_checks = 0;
    int n_err    = 0;
    int viol_neg = 0;
    int viol_pos = 0;
    int equiv_bad = 0;

    logic [CW+DW-1:0] exp_q[$];

    pipe_stage_reg #(
        .CTRL_W(CW), .DATA_W(DW), .CAPTURE_NEGEDGE(1),
        .CTRL_ZERO_ON_BUBBLE(1), .BUB_CNT_W(BW)
    ) u_dut (
        .Clk(Clk), .Reset(Reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
        .bubble_cnt(bubble_cnt), .clr_cnt(clr_cnt)
    );

    pipe_stage_reg #(
        .CTRL_W(CW), .DATA_W(DW), .CAPTURE_NEGEDGE(0),
        .CTRL_ZERO_ON_BUBBLE(1), .BUB_CNT_W(BW)
    ) u_pos (
        .Clk(Clk), .Reset(Reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_p), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid_p), .out_ready(out_ready), .out_ctrl(out_ctrl_p), .out_data(out_data_p),
        .bubble_cnt(bubble_cnt_p), .clr_cnt(clr_cnt)
    );

    // ---------------- clock ----------------
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom();
        return d;
    endfunction

    // Inputs change just after the falling capture edge; tick returns there.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(negedge Clk);
            #1;
        end
    endtask

    task automatic drive(input logic v, input logic [CW-1:0] c);
        in_valid = v;
        in_ctrl  = c;
        in_data  = rand_data();
    endtask

    // ---------------- scoreboard (mid-cycle, handshakes are settled) ----------------
    always @(posedge Clk) begin
        if (Reset || flush) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("sb_underflow", 256'(1), 256'(0));
                else check("sb_order", 256'({out_ctrl, out_data}), 256'(exp_q.pop_front()));
            end
            if (in_valid && in_ready) exp_q.push_back({in_ctrl, in_data});
        end
    end

    // ---------------- edge discipline and twin equivalence ----------------
    logic [SW-1:0] pos_snap;
    logic          have_snap = 1'b0;

    always @(negedge Clk) begin
        pos_snap  = {in_ready_p, out_valid_p, out_ctrl_p, out_data_p, bubble_cnt_p};
        have_snap = 1'b1;
    end

    always @(posedge Clk) begin
        if (have_snap && ({in_ready, out_valid, out_ctrl, out_data, bubble_cnt} !== pos_snap))
            equiv_bad++;
    end

    always @(posedge Clk) begin
        logic [SW-1:0] s;
        s = {in_ready, out_valid, out_ctrl, out_data, bubble_cnt};
        #1;
        if ({in_ready, out_valid, out_ctrl, out_data, bubble_cnt} !== s) viol_neg++;
    end

    always @(negedge Clk) begin
        logic [SW-1:0] s;
        s = {in_ready_p, out_valid_p, out_ctrl_p, out_data_p, bubble_cnt_p};
        #1;
        if ({in_ready_p, out_valid_p, out_ctrl_p, out_data_p, bubble_cnt_p} !== s) viol_pos++;
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [DW-1:0] d8;

        Reset = 1'b1; flush = 1'b0; clr_cnt = 1'b0; out_ready = 1'b1;
        in_valid = 1'b1; in_ctrl = 36'hFFFFFFFFF; in_data = rand_data();

        // Reset held for two edges with junk upstream.
        tick();
        check("rst_valid_e1", 256'(out_valid), 256'(0));
        tick();
        check("rst_valid", 256'(out_valid), 256'(0));
        check("rst_ctrl", 256'(out_ctrl), 256'(0));
        check("rst_data", 256'(out_data), 256'(0));
        check("rst_ready", 256'(in_ready), 256'(1));
        check("rst_bub", 256'(bubble_cnt), 256'(0));

        // Streaming: each entry appears one edge after its Accept.
        Reset = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, CW'(i));
            tick();
            check("stream_valid", 256'(out_valid), 256'(1));
            check("stream_ctrl", 256'(out_ctrl), 256'(i));
            check("stream_ready", 256'(in_ready), 256'(1));
        end
        drive(1'b0, '0);
        tick();
        check("stream_drained", 256'(out_valid), 256'(0));
        check("stream_bub", 256'(bubble_cnt), 256'(1));

        // Backpressure: 5 in main, 6 into skid, 7 waits upstream.
        drive(1'b1, CW'(5));
        tick();
        check("bp_main5", 256'(out_ctrl), 256'(5));
        out_ready = 1'b0;
        drive(1'b1, CW'(6));
        tick();
        check("bp_skid_ready", 256'(in_ready), 256'(0));
        check("bp_hold5", 256'(out_ctrl), 256'(5));
        drive(1'b1, CW'(7));
        tick();
        check("bp_still5", 256'(out_ctrl), 256'(5));
        check("bp_still_full", 256'(in_ready), 256'(0));
        out_ready = 1'b1;
        tick();
        check("bp_out6", 256'(out_ctrl), 256'(6));
        check("bp_ready_back", 256'(in_ready), 256'(1));
        tick();
        check("bp_out7", 256'(out_ctrl), 256'(7));
        drive(1'b0, '0);
        tick();
        check("bp_empty", 256'(out_valid), 256'(0));

        // Flush while full: main = 8, skid = 9, ctrl 10 offered with flush.
        out_ready = 1'b0;
        drive(1'b1, CW'(8));
        d8 = in_data;
        tick();
        drive(1'b1, CW'(9));
        tick();
        flush = 1'b1;
        drive(1'b1, CW'(10));
        tick();
        flush = 1'b0;
        drive(1'b0, '0);
        check("fl_valid", 256'(out_valid), 256'(0));
        check("fl_ctrl", 256'(out_ctrl), 256'(0));
        check("fl_ready", 256'(in_ready), 256'(1));
        check("fl_data_hold", 256'(out_data), 256'(d8));
        tick();
        check("fl_no10", 256'(out_valid), 256'(0));

        // Flush while empty drops a same-cycle Accept; next entry comes through clean.
        out_ready = 1'b1;
        flush = 1'b1;
        drive(1'b1, CW'(11));
        tick();
        flush = 1'b0;
        check("fl_drop11", 256'(out_valid), 256'(0));
        drive(1'b1, CW'(12));
        tick();
        check("fl_next12", 256'(out_ctrl), 256'(12));
        drive(1'b0, '0);
        tick();
        check("fl_no_stale", 256'(out_valid), 256'(0));

        // Reset in the middle of a stall.
        out_ready = 1'b0;
        drive(1'b1, CW'(13));
        tick();
        drive(1'b1, CW'(14));
        tick();
        check("rs_full", 256'(in_ready), 256'(0));
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        drive(1'b0, '0);
        check("rs_valid", 256'(out_valid), 256'(0));
        check("rs_ready", 256'(in_ready), 256'(1));
        check("rs_bub", 256'(bubble_cnt), 256'(0));
        check("rs_ctrl", 256'(out_ctrl), 256'(0));

        // Idle long enough to saturate the 4-bit counter, then clear.
        tick(20);
        check("bub_sat", 256'(bubble_cnt), 256'(15));
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        check("bub_clr", 256'(bubble_cnt), 256'(0));
        tick();
        check("bub_restart", 256'(bubble_cnt), 256'(1));

        // Random traffic with occasional flush; scoreboard does the checking.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), CW'({$urandom(), 4'($urandom())}));
            out_ready = 1'($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            tick();
        end
        flush = 1'b0;
        drive(1'b0, '0);
        out_ready = 1'b1;
        tick(3);
        check("sb_drain", 256'(exp_q.size()), 256'(0));
        check("drain_valid", 256'(out_valid), 256'(0));

        check("edge_neg_only", 256'(viol_neg), 256'(0));
        check("edge_pos_only", 256'(viol_pos), 256'(0));
        check("pos_twin_equiv", 256'(equiv_bad), 256'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised successor to the fixed ID/EXE latch: a generic inter-stage pipeline register carrying a control bundle and a data bundle.
- Adds valid/ready handshaking with a 2-entry skid buffer, synchronous flush with bubble insertion, and a saturating bubble counter.
- Instantiated between any two pipeline stages (IF/ID, ID/EXE, EXE/MEM, MEM/WB) and for multi-cycle FP units.

Parameters:
- CTRL_W, 36, width of the control bundle (ID/EXE packing: [1:0] Alusrc … [35] Rs_Rt_control).
- DATA_W, 192, width of the concatenated data bundle (PC, operands, immediates, register indices).
- CAPTURE_NEGEDGE, 1, 1 = all state updates on the falling edge of Clk; 0 = rising edge.
- CTRL_ZERO_ON_BUBBLE, 1, 1 = out_ctrl forced to 0 whenever out_valid = 0.
- BUB_CNT_W, 16, width of the bubble counter.

Ports:
- Clk  input  1  stage clock; the capture edge is selected by CAPTURE_NEGEDGE.
- Reset  input  1  synchronous, active-high reset, sampled on the capture edge.
- flush  input  1  synchronous squash of all held entries (branch/jump taken).
- in_valid  input  1  upstream entry is valid.
- in_ready  output  1  register can accept an entry this cycle.
- in_ctrl  input  CTRL_W  upstream control bundle.
- in_data  input  DATA_W  upstream data bundle.
- out_valid  output  1  head entry is valid.
- out_ready  input  1  downstream accepts the head entry.
- out_ctrl  output  CTRL_W  head control bundle.
- out_data  output  DATA_W  head data bundle.
- bubble_cnt  output  BUB_CNT_W  count of capture edges with out_valid = 0.
- clr_cnt  input  1  synchronous clear of bubble_cnt.

Behaviour:
- State:
  - main entry: main_v, main_ctrl, main_data.
  - skid entry: skid_v, skid_ctrl, skid_data.
- Outputs:
  - out_valid = main_v; out_ctrl/out_data are driven from main.
  - in_ready = !skid_v, combinational from a register only; there is no comb path from out_ready.
- Accept = in_valid & in_ready. Pop = out_valid & out_ready.
- Reset: main_v = skid_v = 0, all ctrl/data registers = 0, bubble_cnt = 0. Consequently out_valid = 0, out_ctrl = 0, out_data = 0 and in_ready = 1 from the first edge after Reset. Reset overrides flush and all transfers.
- Flush (Reset = 0): main_v and skid_v cleared; main_ctrl and skid_ctrl cleared; data registers hold their value. An Accept in the same cycle is dropped. in_ready is 1 on the next cycle.
- Normal update, on each capture edge:
  - main empty or Pop, skid empty: if Accept, main <- in and main_v = 1; else main_v = 0.
  - main empty or Pop, skid full: main <- skid, skid_v = 0. in_ready was 0, so there is no Accept.
  - main full, no Pop, Accept: skid <- in, skid_v = 1.
  - main full, no Pop, no Accept: hold.
- Latency and throughput:
  - Latency is 1 capture edge from Accept to out_valid, with an empty register.
  - Sustained throughput is 1 entry per cycle while out_ready = 1.
  - Order is strictly FIFO; entries are never duplicated or lost.
- Stall: out_ready = 0 with main full fills the skid. in_ready deasserts the following cycle, and one further entry is absorbed.
- Bubble display: with CTRL_ZERO_ON_BUBBLE = 1, out_ctrl = 0 whenever out_valid = 0, so the control word is a NOP/bubble. out_data still shows the last main_data.
- bubble_cnt:
  - Increments on every capture edge where main_v is 0 before the edge; saturates at all-ones.
  - clr_cnt takes precedence over increment; Reset clears it.
- Width rule: ctrl and data are copied bit-exact; there is no arithmetic on the payload.

Test Plan:
- Reset and streaming:
  - Stimulus: hold Reset 2 edges with in_valid = 1, in_ctrl = 36'hFFFFFFFFF; then release, out_ready = 1, stream ctrl 1, 2, 3, 4.
  - Required: out_valid = 0 and out_ctrl = 0 during Reset. After release, out_ctrl = 1, 2, 3, 4 on consecutive edges, each 1 edge after its Accept. in_ready stays 1.
- Backpressure:
  - Stimulus: main holds ctrl 5; out_ready = 0; present ctrl 6, then ctrl 7.
  - Required: 6 goes to the skid; in_ready = 0 next cycle; 7 is held upstream. After out_ready = 1, out_ctrl = 5, 6, 7 in order with no loss.
- Flush while full:
  - Stimulus: main = 8, skid = 9, flush = 1 together with in_valid = 1, ctrl 10.
  - Required: next edge out_valid = 0, out_ctrl = 0, in_ready = 1. Ctrl 10 is not captured.
- Reset mid-stall:
  - Stimulus: skid full, out_ready = 0; assert Reset.
  - Required: out_valid = 0, in_ready = 1, bubble_cnt = 0 after 1 edge.
- Bubble counter:
  - Stimulus: BUB_CNT_W = 4; idle for 20 edges.
  - Required: bubble_cnt = 15 (saturated). Asserting clr_cnt on an idle edge gives 0.
- Edge mode:
  - Stimulus: CAPTURE_NEGEDGE = 0 vs 1, same stimulus.
  - Required: outputs change only on the rising or only on the falling Clk edge respectively.
